instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/fetch_timeout_ctr.sv | 30 +++
 rtl/instr_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding and default widths.
// INSTR_FETCH_TIMEOUT_EN (see instr_fetch.sv) enables the memory-timeout logic.
package instr_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Down-counter that flags a memory read exceeding TIMEOUT cycles in BUSY.
// Only instantiated when INSTR_FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count;

  // Loaded with TIMEOUT-1 so terminal count lands on the TIMEOUT-th waiting cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory read per fetch_start and holds the result in ir.
// Build option: define INSTR_FETCH_TIMEOUT_EN to abort reads that exceed TIMEOUT cycles.
//
// state | meaning
// IDLE  | no read outstanding, ir_valid=0
// BUSY  | read outstanding, mem_req=1
// FULL  | ir holds an unconsumed instruction
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_start,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_consume,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t state;
  logic         fetch_go;
  logic         timeout;

  // A new read starts from IDLE, or from FULL when the held word is consumed.
  assign fetch_go = !flush && fetch_start &&
                    ((state == ST_IDLE) || ((state == ST_FULL) && ir_consume));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      ir       <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else if (fetch_go) begin
      mem_addr <= pc;
      state    <= ST_BUSY;
    end else begin
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_BUSY: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= ST_FULL;
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        ST_FULL: begin
          if (ir_consume) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req  = (state == ST_BUSY);
  assign ir_valid = (state == ST_FULL);
  assign busy     = (state != ST_IDLE);

`ifdef INSTR_FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .load   (fetch_go),
    .run    ((state == ST_BUSY) && !mem_ack && !flush),
    .expired(timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (timeout) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule
